// File: rtl/coa_pkg.sv
// ============================================================================
// coa_pkg: shared defaults and FSM encoding for the toggle-link receiver. Rev 1.0
// ============================================================================
`default_nettype none

package coa_pkg;

    localparam int W_DEF     = 4;
    localparam int SYNC_DEF  = 2;
    localparam int CNT_W_DEF = 8;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/toggle_stream_decoder_sync_edge.sv
// ============================================================================
// sync_edge: multi-flop synchroniser for a toggle line plus change detector. Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge
    import coa_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_s,
    output logic o_b
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s = r_sync[SYNC_STAGES-1];
    // A level change between consecutive samples is a transmitted 1.
    assign o_b = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

`default_nettype wire

// File: rtl/toggle_stream_decoder.sv
// ============================================================================
// toggle_stream_decoder: recovers LSB-first words from a toggle line, buffers
// one word behind a valid/ready handshake and counts toggle events. Rev 1.0
// ============================================================================
`default_nettype none

module toggle_stream_decoder
    import coa_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Tin,
    input  logic             En,
    input  logic             Clr,
    input  logic             Ready,
    output logic [W-1:0]     Data,
    output logic             Valid,
    output logic             Overflow,
    output logic [CNT_W-1:0] EvCnt
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic             w_b;
    logic [CW-1:0]    w_idx;
    logic             w_last;
    logic [W-1:0]     w_word;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_shift;
    logic [W-1:0]     r_data;
    logic             r_valid;
    logic             r_ovf;
    logic [CNT_W-1:0] r_evcnt;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (Clk),
        .rst_n (Rst),
        .i_d   (Tin),
        .o_s   (),
        .o_b   (w_b)
    );

    // The bit decoded on the cycle En rises is always bit 0 of the frame.
    assign w_idx  = (r_state == ST_IDLE) ? '0 : r_cnt;
    assign w_last = En && (w_idx == CW'(W - 1));

    always_comb begin
        w_word        = r_shift;
        w_word[w_idx] = w_b;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (En) begin
            r_state <= ST_COLLECT;
            if (w_last) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else begin
                r_cnt   <= w_idx + CW'(1);
                r_shift <= w_word;
            end
        end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end
    end

    // A completed word is accepted if the buffer is empty or draining this cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_last) begin
                if (!r_valid || Ready) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_valid && Ready) begin
                r_valid <= 1'b0;
            end
            if (Clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_evcnt <= '0;
        end else if (Clr) begin
            r_evcnt <= '0;
        end else if (En && w_b) begin
            r_evcnt <= r_evcnt + CNT_W'(1);
        end
    end

    assign Data     = r_data;
    assign Valid    = r_valid;
    assign Overflow = r_ovf;
    assign EvCnt    = r_evcnt;

endmodule

`default_nettype wire

// File: tb/tb_toggle_stream_decoder.sv
// ============================================================================
// tb_toggle_stream_decoder: directed and random stimulus against a queue-based
// reference of the toggle-link receiver. Rev 1.0
// ============================================================================
`default_nettype none

module tb_toggle_stream_decoder;

    localparam int W     = 4;
    localparam int SYNC  = 2;
    localparam int CNT_W = 8;

    logic             Clk   = 1'b0;
    logic             Rst   = 1'b1;
    logic             Tin   = 1'b0;
    logic             En    = 1'b0;
    logic             Clr   = 1'b0;
    logic             Ready = 1'b0;
    logic [W-1:0]     Data;
    logic             Valid;
    logic             Overflow;
    logic [CNT_W-1:0] EvCnt;

    int n_checks = 0;
    int n_errors = 0;
    int vcount   = 0;

    // Reference state: Tin history, pending En delay line, frame bits so far.
    logic hist[$];
    logic enq[$];
    int   bits[$];
    logic [W-1:0]     m_data;
    logic             m_valid;
    logic             m_ovf;
    logic [CNT_W-1:0] m_ev;

    always #5 Clk = ~Clk;

    toggle_stream_decoder #(
        .W           (W),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tin      (Tin),
        .En       (En),
        .Clr      (Clr),
        .Ready    (Ready),
        .Data     (Data),
        .Valid    (Valid),
        .Overflow (Overflow),
        .EvCnt    (EvCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic lvl(input int d);
        if (hist.size() > d) return hist[hist.size() - 1 - d];
        return 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        bits.delete();
        enq.delete();
        repeat (SYNC) enq.push_back(1'b0);
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_ev    = '0;
    endtask

    // Decoded bit at an edge is the change between the Tin levels SYNC and
    // SYNC+1 edges back; words are accumulated LSB-first by arithmetic.
    task automatic model_step();
        logic b;
        logic done;
        int   word;
        hist.push_back(Tin);
        if (hist.size() > 16) void'(hist.pop_front());
        b    = lvl(SYNC) ^ lvl(SYNC + 1);
        done = 1'b0;
        word = 0;
        if (En) begin
            bits.push_back(int'(b));
            if (b) m_ev = m_ev + 1'b1;
            if (bits.size() == W) begin
                for (int i = 0; i < W; i++) word += bits[i] * (1 << i);
                bits.delete();
                done = 1'b1;
            end
        end else begin
            bits.delete();
        end
        if (done) begin
            if (!m_valid || Ready) begin
                m_data  = W'(word);
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && Ready) begin
            m_valid = 1'b0;
        end
        if (Clr) begin
            m_ovf = 1'b0;
            m_ev  = '0;
        end
    endtask

    // One clock: b=1 toggles Tin; want is the En intended for this bit, which
    // reaches the DUT after the synchroniser latency.
    task automatic cyc(input logic b, input logic want, input logic rdy, input logic clr);
        if (b) Tin = ~Tin;
        enq.push_back(want);
        En    = enq.pop_front();
        Ready = rdy;
        Clr   = clr;
        @(posedge Clk);
        model_step();
        #1;
        chk("data", 32'(Data), 32'(m_data));
        chk("valid", 32'(Valid), 32'(m_valid));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
        chk("evcnt", 32'(EvCnt), 32'(m_ev));
        if (Valid) vcount++;
    endtask

    task automatic send(input logic [W-1:0] w, input logic rdy);
        for (int i = 0; i < W; i++) cyc(w[i], 1'b1, rdy, 1'b0);
    endtask

    task automatic flush(input logic rdy);
        cyc(1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        model_reset();
        #2 Rst = 1'b0;
        #1;
        chk("reset_data", 32'(Data), 32'h0);
        chk("reset_valid", 32'(Valid), 32'h0);
        chk("reset_overflow", 32'(Overflow), 32'h0);
        chk("reset_evcnt", 32'(EvCnt), 32'h0);
        @(posedge Clk);
        @(posedge Clk);
        #3 Rst = 1'b1;

        // Single word: Tin levels 1,1,0,1 decode to bits 1,0,1,1.
        send(4'b1101, 1'b1);
        flush(1'b1);
        flush(1'b1);
        chk("single_data", 32'(Data), 32'hD);
        chk("single_valid", 32'(Valid), 32'h1);
        chk("single_evcnt", 32'(EvCnt), 32'd3);
        flush(1'b1);
        chk("single_valid_drop", 32'(Valid), 32'h0);

        // No toggles for 8 bit times: two zero words, no events.
        vcount = 0;
        repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        flush(1'b1);
        flush(1'b1);
        chk("idle_words", 32'(vcount), 32'd2);
        chk("idle_data", 32'(Data), 32'h0);
        chk("idle_evcnt", 32'(EvCnt), 32'd3);
        flush(1'b1);

        // Backpressure: second word is dropped and flags overflow.
        send(4'b1111, 1'b0);
        send(4'b0101, 1'b0);
        flush(1'b0);
        flush(1'b0);
        chk("bp_data", 32'(Data), 32'hF);
        chk("bp_valid", 32'(Valid), 32'h1);
        chk("bp_overflow", 32'(Overflow), 32'h1);
        flush(1'b1);
        chk("bp_drain", 32'(Valid), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_clr_overflow", 32'(Overflow), 32'h0);
        chk("bp_clr_evcnt", 32'(EvCnt), 32'h0);

        // Reach Valid=1, Overflow=1, EvCnt=5, then reset between edges.
        send(4'b1111, 1'b0);
        send(4'b1000, 1'b0);
        flush(1'b0);
        flush(1'b0);
        chk("pre_rst_valid", 32'(Valid), 32'h1);
        chk("pre_rst_overflow", 32'(Overflow), 32'h1);
        chk("pre_rst_evcnt", 32'(EvCnt), 32'd5);
        #2 Rst = 1'b0;
        #1;
        chk("async_rst_data", 32'(Data), 32'h0);
        chk("async_rst_valid", 32'(Valid), 32'h0);
        chk("async_rst_overflow", 32'(Overflow), 32'h0);
        chk("async_rst_evcnt", 32'(EvCnt), 32'h0);
        @(posedge Clk);
        #1;
        chk("held_rst_valid", 32'(Valid), 32'h0);
        chk("held_rst_evcnt", 32'(EvCnt), 32'h0);
        Tin   = 1'b0;
        En    = 1'b0;
        Ready = 1'b0;
        Clr   = 1'b0;
        model_reset();
        #1 Rst = 1'b1;

        // Accept and completion in the same cycle.
        send(4'b0011, 1'b0);
        send(4'b1010, 1'b0);
        flush(1'b0);
        chk("simul_pre_data", 32'(Data), 32'h3);
        chk("simul_pre_valid", 32'(Valid), 32'h1);
        flush(1'b1);
        chk("simul_data", 32'(Data), 32'hA);
        chk("simul_valid", 32'(Valid), 32'h1);
        chk("simul_overflow", 32'(Overflow), 32'h0);
        flush(1'b1);

        // Abort after two bits, then a clean frame starting at bit 0.
        vcount = 0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) flush(1'b1);
        chk("abort_no_valid", 32'(vcount), 32'd0);
        send(4'b0110, 1'b1);
        flush(1'b1);
        flush(1'b1);
        chk("abort_next_data", 32'(Data), 32'h6);
        chk("abort_next_valid", 32'(Valid), 32'h1);

        // 256 toggles wrap the event counter; Ready high means no overflow.
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (256) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        flush(1'b1);
        flush(1'b1);
        chk("wrap_evcnt", 32'(EvCnt), 32'h0);
        chk("wrap_overflow", 32'(Overflow), 32'h0);
        chk("wrap_data", 32'(Data), 32'hF);

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/toggle_stream_decoder.md
Name: toggle_stream_decoder

Overview:
Receive-side counterpart of the toggle-flop link driven by the System block. System emits a toggle line whose level changes once per bit period whenever its combinational term is 1. This block synchronises that line and recovers each bit as "line changed vs. previous sample". It packs the bits LSB-first into W-bit words, presents them through a one-entry valid/ready holding buffer, and counts toggle events.

Parameters:
W, 4, decoded word width in bits (the In width of the transmitter side)
SYNC_STAGES, 2, synchroniser flops on Tin (≥2)
CNT_W, 8, width of event counter

Ports:
Clk  input  1  clock; all state updates on posedge
Rst  input  1  asynchronous, active-low reset (Rst=0 clears all state immediately)
Tin  input  1  toggle line from the transmitter's Tff Q output
En  input  1  frame enable; while 0, decoding is idle and the bit counter is held at 0
Clr  input  1  synchronous clear of Overflow and EvCnt
Ready  input  1  consumer accepts Data when Valid&Ready
Data  output  W  decoded word; bit 0 = first bit of frame
Valid  output  1  holding buffer full
Overflow  output  1  sticky; a completed word was dropped
EvCnt  output  CNT_W  number of toggles detected while En=1, wraps modulo 2^CNT_W

Behaviour:
- Reset (Rst=0, async): sync chain=0, prev sample p=0, shift reg=0, bit count=0, Data=0, Valid=0, Overflow=0, EvCnt=0, state=IDLE. The decoder idles like the transmitter's Q after reset.
- Sync: Tin passes through SYNC_STAGES flops to give s. p<=s every cycle, regardless of En.
- Decoded bit each cycle: b = s ^ p.
- Latency: a Tin edge appears as b=1 exactly SYNC_STAGES cycles after the first posedge that samples it.
- FSM:
  - IDLE: bit count=0; on En=1 go to COLLECT. The bit computed in that same cycle is bit 0.
  - COLLECT: each cycle with En=1, shift b into position cnt and increment cnt. When cnt reaches W-1 and the bit is taken, the word is complete, cnt returns to 0, and the FSM stays in COLLECT. If En drops, discard the partial word, set cnt=0 and go to IDLE. A completed word is never discarded by En.
- Word completion (cycle N):
  - holding empty, or Valid&Ready in cycle N: Data<=word and Valid=1 from N+1.
  - holding full and Ready=0: word is dropped, Overflow<=1, and Data/Valid are unchanged.
- Consumer handshake: when Valid&Ready and no completion in the same cycle, Valid<=0 next cycle. Data holds its value until reloaded.
- Valid, once set, stays set until a handshake occurs. Data is stable while Valid=1 and Ready=0.
- EvCnt: +1 on each cycle with En=1 and b=1. Wraps from 2^CNT_W-1 to 0.
- Clr=1: Overflow<=0 and EvCnt<=0 next cycle. If an overflow or event occurs in the same cycle, Clr wins.
- Throughput: one word per W cycles. With Ready tied high, Overflow never sets.

Decomposition:
- Shared package coa_pkg:
  - localparam defaults W_DEF=4, SYNC_DEF=2, CNT_W_DEF=8
  - state encoding constants ST_IDLE=1'b0, ST_COLLECT=1'b1
- One sub-module, sync_edge:
  - parameterised synchroniser plus prev-sample register
  - outputs s and b=s^p
  - reusable by any block that reads toggle lines
- Top module: FSM, shift/count, holding buffer, counters.

Test Plan:
- Reset mid-operation: with Valid=1, Overflow=1, EvCnt=5, pulse Rst=0 between clock edges. All outputs must go to 0 immediately, without waiting for an edge, and hold at 0 while Rst=0.
- Single word: drive Tin levels 1,1,0,1 (one per cycle from 0) with En=1 aligned to the first decoded bit and Ready=1.
  - Data=4'b1101 and Valid=1 one cycle after the 4th bit, for 1 cycle.
  - EvCnt=3.
- No toggles: Tin held 0, En=1 for 8 cycles. Two words of 4'b0000 are delivered and EvCnt=0.
- Backpressure: Ready=0, stream words 4'b1111 then 4'b0101.
  - Data stays 4'b1111, Valid=1, Overflow=1 after the second word.
  - Then Ready=1 for 1 cycle: Valid=0.
  - Clr pulse: Overflow=0.
- Simultaneous accept and complete: with Valid=1, raise Ready=1 in the exact cycle word 4'b1010 completes. Data=4'b1010, Valid stays 1, Overflow stays 0.
- En abort and wrap:
  - Drop En after 2 bits. No Valid, and the next frame starts at bit 0.
  - With CNT_W=8, force 256 toggles. EvCnt wraps to 0.
